multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle MIPS control unit: a Moore-style state machine that sequences one instruction over 3–5 cycles and drives all datapath enables and mux selects. It replaces the single-cycle opcode decoder in the multicycle datapath, sitting between the instruction register's opcode field and the PC, memory, register-file and ALU control inputs. Compared with the single-cycle decoder it adds `addi` and `j` support (parameter-gated), memory wait-state handling, illegal-opcode flagging and a retired-instruction counter.

## Interface
- `OPCODE_W`, 6: opcode width.
- `ENABLE_ADDI`, 1: 1 decodes `addi` (001000); 0 treats it as illegal.
- `ENABLE_JUMP`, 1: 1 decodes `j` (000010); 0 treats it as illegal.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  OPCODE_W  IR[31:26]; sampled in DECODE only.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath controls.
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `ALUOp`  out  2  00 add, 01 subtract, 10 funct-decoded.
- `ALUSrcB`  out  2  00 B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `illegal_op`  out  1  one-cycle pulse; unsupported opcode seen in DECODE.
- `instr_count`  out  CNT_W  instructions retired since reset.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready. Go to DECODE on mem_ready; otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch-target precompute). Next state: 100011/101011→MEMADR, 000000→RTYPE_EX, 000100→BRANCH, 001000→ADDI_EX (if enabled), 000010→JUMP (if enabled); anything else→FETCH with `illegal_op`=1 this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw; the opcode is re-read from the stable IR.
- MEMRD: MemRead=1, IorD=1; hold until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
- MEMWR: MemWrite=1, IorD=1; hold until mem_ready, then FETCH.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- Any output not listed for a state is 0.
- `instr_count` increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTYPE_WB, BRANCH, ADDI_WB or JUMP. It wraps modulo 2^CNT_W and does not increment on the illegal path.

## Timing
- Reset (asynchronous): state=FETCH, instr_count=0. Outputs immediately take FETCH values with mem_ready=0: MemRead=1, ALUSrcB=01, everything else 0, illegal_op=0.
- Reset asserted mid-instruction aborts it at once; no further write enables assert, and the aborted instruction is not counted.
- Latency with mem_ready held at 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3; illegal opcode 2 (FETCH, DECODE). Each low cycle of mem_ready in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- Outputs are combinational from the state register. mem_ready reaches only IRWrite and PCWrite in FETCH, plus the next-state logic.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the state enum;
  - ALUOp, ALUSrcB and PCSource encodings.
- Natural sub-module: `mc_output_decode`, a purely combinational mapping from state and mem_ready to the control outputs. The top level keeps the state register, next-state logic and counter.

## Test plan
- Reset asserted, then released with mem_ready=1 → FETCH outputs as listed, instr_count=0, illegal_op=0.
- lw then sw, mem_ready=1 → lw takes 5 cycles with MemtoReg=RegWrite=1 in cycle 5; sw takes 4 cycles with MemWrite=1 in cycle 4; instr_count=2.
- lw with mem_ready=0 for 3 cycles in MEMRD → state holds in MEMRD with MemRead=IorD=1 and RegWrite stays 0; total 8 cycles.
- beq → PCWriteCond=1, PCSource=01, ALUOp=01 in cycle 3. j → PCWrite=1, PCSource=10 in cycle 3.
- Build with ENABLE_ADDI=0 and apply opcode 001000 → illegal_op=1 in DECODE, return to FETCH, instr_count unchanged, RegWrite never asserted.
- With CNT_W=4, run 17 R-type instructions → instr_count=1. Assert reset during RTYPE_EX → RegWrite stays 0 and state=FETCH asynchronously.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, FSM states and control encodings for the multicycle MIPS controller.
package mips_ctrl_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPE_EX,
        RTYPE_WB,
        BRANCH,
        ADDI_EX,
        ADDI_WB,
        JUMP
    } stateT;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full datapath control word driven by the output decoder
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       aluSrcA;
        logic       regWrite;
        logic       regDst;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic [1:0] aluSrcB;
    } ctrlT;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state-to-control-word mapping for the multicycle controller.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  stateT state,
    input  logic  memReady,
    output ctrlT  ctrl
);

    // Moore control word per state; memReady only gates the IR/PC writes in FETCH
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = PCSRC_ALU;
                ctrl.irWrite  = memReady;
                ctrl.pcWrite  = memReady;
            end
            DECODE: begin
                ctrl.aluSrcB = SRCB_IMM_SH2;
                ctrl.aluOp   = ALUOP_ADD;
            end
            MEMADR, ADDI_EX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = 1'b1;
            end
            MEMWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            RTYPE_EX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_B;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            RTYPE_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_B;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
            end
            ADDI_WB: begin
                ctrl.regWrite = 1'b1;
            end
            JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic and retired-instruction counter.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 6,
    parameter bit          ENABLE_ADDI = 1'b1,
    parameter bit          ENABLE_JUMP = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                ALUSrcA,
    output logic                RegWrite,
    output logic                RegDst,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUOp,
    output logic [1:0]          ALUSrcB,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    instr_count
);

    stateT state;
    stateT nextState;
    ctrlT  ctrl;
    logic  isLw;
    logic  isSw;
    logic  isRtype;
    logic  isBeq;
    logic  isAddi;
    logic  isJump;
    logic  retire;

    assign isLw    = (opcode == OPCODE_W'(OP_LW));
    assign isSw    = (opcode == OPCODE_W'(OP_SW));
    assign isRtype = (opcode == OPCODE_W'(OP_RTYPE));
    assign isBeq   = (opcode == OPCODE_W'(OP_BEQ));
    assign isAddi  = (opcode == OPCODE_W'(OP_ADDI)) && ENABLE_ADDI;
    assign isJump  = (opcode == OPCODE_W'(OP_J)) && ENABLE_JUMP;

    // Next-state selection and the DECODE-cycle illegal-opcode pulse
    always_comb begin
        nextState  = state;
        illegal_op = 1'b0;
        case (state)
            FETCH:    if (mem_ready) nextState = DECODE;
            DECODE: begin
                if (isLw || isSw)  nextState = MEMADR;
                else if (isRtype)  nextState = RTYPE_EX;
                else if (isBeq)    nextState = BRANCH;
                else if (isAddi)   nextState = ADDI_EX;
                else if (isJump)   nextState = JUMP;
                else begin
                    nextState  = FETCH;
                    illegal_op = 1'b1;
                end
            end
            MEMADR:   nextState = isLw ? MEMRD : MEMWR;
            MEMRD:    if (mem_ready) nextState = MEMWB;
            MEMWB:    nextState = FETCH;
            MEMWR:    if (mem_ready) nextState = FETCH;
            RTYPE_EX: nextState = RTYPE_WB;
            RTYPE_WB: nextState = FETCH;
            BRANCH:   nextState = FETCH;
            ADDI_EX:  nextState = ADDI_WB;
            ADDI_WB:  nextState = FETCH;
            JUMP:     nextState = FETCH;
            default:  nextState = FETCH;
        endcase
    end

    // An instruction retires when a final-step state hands control back to FETCH
    assign retire = (nextState == FETCH) &&
                    (state inside {MEMWB, MEMWR, RTYPE_WB, BRANCH, ADDI_WB, JUMP});

    // State register and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            instr_count <= '0;
        end else begin
            state <= nextState;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    mc_output_decode uDecode (
        .state    (state),
        .memReady (mem_ready),
        .ctrl     (ctrl)
    );

    assign PCWrite     = ctrl.pcWrite;
    assign PCWriteCond = ctrl.pcWriteCond;
    assign IorD        = ctrl.iorD;
    assign MemRead     = ctrl.memRead;
    assign MemWrite    = ctrl.memWrite;
    assign IRWrite     = ctrl.irWrite;
    assign MemtoReg    = ctrl.memtoReg;
    assign ALUSrcA     = ctrl.aluSrcA;
    assign RegWrite    = ctrl.regWrite;
    assign RegDst      = ctrl.regDst;
    assign PCSource    = ctrl.pcSource;
    assign ALUOp       = ctrl.aluOp;
    assign ALUSrcB     = ctrl.aluSrcB;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction phase model with randomized opcodes and memory waits.
module tb_multicycle_control;

    localparam int NDUT = 3;

    // Instruction steps as listed for the controller, numbered locally
    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_MEMADR = 2;
    localparam int PH_MEMRD  = 3;
    localparam int PH_MEMWB  = 4;
    localparam int PH_MEMWR  = 5;
    localparam int PH_REX    = 6;
    localparam int PH_RWB    = 7;
    localparam int PH_BRANCH = 8;
    localparam int PH_AEX    = 9;
    localparam int PH_AWB    = 10;
    localparam int PH_JUMP   = 11;

    localparam logic [5:0] C_RTYPE = 6'b000000;
    localparam logic [5:0] C_LW    = 6'b100011;
    localparam logic [5:0] C_SW    = 6'b101011;
    localparam logic [5:0] C_BEQ   = 6'b000100;
    localparam logic [5:0] C_ADDI  = 6'b001000;
    localparam logic [5:0] C_J     = 6'b000010;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;

    logic PCWrite[NDUT], PCWriteCond[NDUT], IorD[NDUT], MemRead[NDUT], MemWrite[NDUT];
    logic IRWrite[NDUT], MemtoReg[NDUT], ALUSrcA[NDUT], RegWrite[NDUT], RegDst[NDUT];
    logic illegal_op[NDUT];
    logic [1:0] PCSource[NDUT], ALUOp[NDUT], ALUSrcB[NDUT];
    logic [31:0] cntA;
    logic [31:0] cntB;
    logic [3:0]  cntC;

    int checks   = 0;
    int failures = 0;
    int unsigned expCount;

    always #5 clk = ~clk;

    // dut 0: default build
    multicycle_control dutA (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite[0]), .PCWriteCond(PCWriteCond[0]), .IorD(IorD[0]), .MemRead(MemRead[0]),
        .MemWrite(MemWrite[0]), .IRWrite(IRWrite[0]), .MemtoReg(MemtoReg[0]), .ALUSrcA(ALUSrcA[0]),
        .RegWrite(RegWrite[0]), .RegDst(RegDst[0]), .PCSource(PCSource[0]), .ALUOp(ALUOp[0]),
        .ALUSrcB(ALUSrcB[0]), .illegal_op(illegal_op[0]), .instr_count(cntA)
    );

    // dut 1: addi and j disabled
    multicycle_control #(.ENABLE_ADDI(1'b0), .ENABLE_JUMP(1'b0)) dutB (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite[1]), .PCWriteCond(PCWriteCond[1]), .IorD(IorD[1]), .MemRead(MemRead[1]),
        .MemWrite(MemWrite[1]), .IRWrite(IRWrite[1]), .MemtoReg(MemtoReg[1]), .ALUSrcA(ALUSrcA[1]),
        .RegWrite(RegWrite[1]), .RegDst(RegDst[1]), .PCSource(PCSource[1]), .ALUOp(ALUOp[1]),
        .ALUSrcB(ALUSrcB[1]), .illegal_op(illegal_op[1]), .instr_count(cntB)
    );

    // dut 2: 4-bit counter
    multicycle_control #(.CNT_W(4)) dutC (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite[2]), .PCWriteCond(PCWriteCond[2]), .IorD(IorD[2]), .MemRead(MemRead[2]),
        .MemWrite(MemWrite[2]), .IRWrite(IRWrite[2]), .MemtoReg(MemtoReg[2]), .ALUSrcA(ALUSrcA[2]),
        .RegWrite(RegWrite[2]), .RegDst(RegDst[2]), .PCSource(PCSource[2]), .ALUOp(ALUOp[2]),
        .ALUSrcB(ALUSrcB[2]), .illegal_op(illegal_op[2]), .instr_count(cntC)
    );

    function automatic logic [16:0] obsWord(input int d);
        return {PCWrite[d], PCWriteCond[d], IorD[d], MemRead[d], MemWrite[d], IRWrite[d],
                MemtoReg[d], ALUSrcA[d], RegWrite[d], RegDst[d], PCSource[d], ALUOp[d],
                ALUSrcB[d], illegal_op[d]};
    endfunction

    function automatic logic [31:0] obsCount(input int d);
        if (d == 0) return cntA;
        if (d == 1) return cntB;
        return 32'(cntC);
    endfunction

    function automatic logic [31:0] cntMask(input int d);
        return (d == 2) ? 32'h0000_000F : 32'hFFFF_FFFF;
    endfunction

    // Expected control word for one step, straight from the per-state output table
    function automatic logic [16:0] expWord(input int ph, input logic rdy, input logic ill);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst;
        logic [1:0] pcsrc, aluop, srcb;
        pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0; srca = 0; rw = 0; rdst = 0;
        pcsrc = 2'b00; aluop = 2'b00; srcb = 2'b00;
        case (ph)
            PH_FETCH:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            PH_DECODE: srcb = 2'b11;
            PH_MEMADR: begin srca = 1; srcb = 2'b10; end
            PH_MEMRD:  begin mrd = 1; iord = 1; end
            PH_MEMWB:  begin rw = 1; m2r = 1; end
            PH_MEMWR:  begin mwr = 1; iord = 1; end
            PH_REX:    begin srca = 1; aluop = 2'b10; end
            PH_RWB:    begin rw = 1; rdst = 1; end
            PH_BRANCH: begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
            PH_AEX:    begin srca = 1; srcb = 2'b10; end
            PH_AWB:    rw = 1;
            PH_JUMP:   begin pcw = 1; pcsrc = 2'b10; end
            default:   ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst, pcsrc, aluop, srcb,
                (ph == PH_DECODE) ? ill : 1'b0};
    endfunction

    function automatic bit isLegal(input logic [5:0] op, input int d);
        return (op == C_LW) || (op == C_SW) || (op == C_RTYPE) || (op == C_BEQ) ||
               ((op == C_ADDI) && (d != 1)) || ((op == C_J) && (d != 1));
    endfunction

    // Drive one instruction through its steps; negative low-counts pick a random 0..2 wait
    task automatic runInstr(input logic [5:0] op, input int d, input int fetchLow,
                            input int memLow, output int cycles);
        int seq[$];
        bit legal;
        logic [16:0] exp;
        legal = isLegal(op, d);
        seq.push_back(PH_FETCH);
        seq.push_back(PH_DECODE);
        if (legal) begin
            if (op == C_LW) begin
                seq.push_back(PH_MEMADR); seq.push_back(PH_MEMRD); seq.push_back(PH_MEMWB);
            end else if (op == C_SW) begin
                seq.push_back(PH_MEMADR); seq.push_back(PH_MEMWR);
            end else if (op == C_RTYPE) begin
                seq.push_back(PH_REX); seq.push_back(PH_RWB);
            end else if (op == C_BEQ) begin
                seq.push_back(PH_BRANCH);
            end else if (op == C_ADDI) begin
                seq.push_back(PH_AEX); seq.push_back(PH_AWB);
            end else begin
                seq.push_back(PH_JUMP);
            end
        end
        cycles = 0;
        foreach (seq[k]) begin
            int p;
            int lows;
            bit waits;
            p = seq[k];
            waits = (p == PH_FETCH) || (p == PH_MEMRD) || (p == PH_MEMWR);
            lows = 0;
            if (waits) begin
                lows = (p == PH_FETCH) ? fetchLow : memLow;
                if (lows < 0) lows = int'($urandom_range(2, 0));
            end
            for (int c = 0; c <= lows; c++) begin
                @(negedge clk);
                opcode = op;
                if (waits) mem_ready = (c == lows);
                else       mem_ready = 1'($urandom_range(1, 0));
                #1;
                exp = expWord(p, mem_ready, !legal);
                checks++;
                if (obsWord(d) !== exp) begin
                    failures++;
                    $display("FAIL ctrl dut%0d op=%b step=%0d cyc=%0d got=%b expected=%b",
                             d, op, p, cycles, obsWord(d), exp);
                end
                cycles++;
            end
        end
        if (legal) expCount++;
        @(posedge clk);
        #1;
        checks++;
        if ((obsCount(d) & cntMask(d)) !== (32'(expCount) & cntMask(d))) begin
            failures++;
            $display("FAIL count dut%0d op=%b got=%0d expected=%0d", d, op,
                     obsCount(d), 32'(expCount) & cntMask(d));
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expCount = 0;
    endtask

    task automatic checkLatency(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL latency_%s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        logic [16:0] exp;
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        exp = expWord(PH_FETCH, 1'b0, 1'b0);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (obsWord(d) !== exp || obsCount(d) !== 32'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%b/%0d expected=%b/0", d, obsWord(d), obsCount(d), exp);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        expCount = 0;
        #1;
        exp = expWord(PH_FETCH, 1'b1, 1'b0);
        checks++;
        if (obsWord(0) !== exp || cntA !== 32'd0) begin
            failures++;
            $display("FAIL reset_release got=%b/%0d expected=%b/0", obsWord(0), cntA, exp);
        end
    endtask

    task automatic test_lw_sw();
        int cyc;
        doReset();
        runInstr(C_LW, 0, 0, 0, cyc);
        checkLatency("lw", cyc, 5);
        runInstr(C_SW, 0, 0, 0, cyc);
        checkLatency("sw", cyc, 4);
        checks++;
        if (cntA !== 32'd2) begin
            failures++;
            $display("FAIL lw_sw_count got=%0d expected=2", cntA);
        end
    endtask

    task automatic test_mem_wait();
        int cyc;
        runInstr(C_LW, 0, 0, 3, cyc);
        checkLatency("lw_wait3", cyc, 8);
        runInstr(C_SW, 0, 2, 1, cyc);
        checkLatency("sw_wait", cyc, 7);
    endtask

    task automatic test_branch_jump();
        int cyc;
        runInstr(C_BEQ, 0, 0, 0, cyc);
        checkLatency("beq", cyc, 3);
        runInstr(C_J, 0, 0, 0, cyc);
        checkLatency("j", cyc, 3);
        runInstr(C_ADDI, 0, 0, 0, cyc);
        checkLatency("addi", cyc, 4);
        runInstr(C_RTYPE, 0, 0, 0, cyc);
        checkLatency("rtype", cyc, 4);
        runInstr(6'b111111, 0, 0, 0, cyc);
        checkLatency("illegal", cyc, 2);
    endtask

    task automatic test_illegal_disabled();
        int cyc;
        doReset();
        runInstr(C_RTYPE, 1, 0, 0, cyc);
        runInstr(C_ADDI, 1, 0, 0, cyc);
        checkLatency("addi_disabled", cyc, 2);
        runInstr(C_J, 1, 1, 0, cyc);
        checkLatency("j_disabled", cyc, 3);
        checks++;
        if (cntB !== 32'd1) begin
            failures++;
            $display("FAIL illegal_count got=%0d expected=1", cntB);
        end
    endtask

    task automatic test_counter_wrap();
        int cyc;
        doReset();
        for (int i = 0; i < 17; i++) runInstr(C_RTYPE, 2, 0, 0, cyc);
        checks++;
        if (cntC !== 4'd1) begin
            failures++;
            $display("FAIL wrap_count got=%0d expected=1", cntC);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        logic [16:0] exp;
        doReset();
        runInstr(C_RTYPE, 0, 0, 0, cyc);
        @(negedge clk); opcode = C_RTYPE; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ALUOp[0] !== 2'b10) begin
            failures++;
            $display("FAIL abort_in_rtype_ex got ALUOp=%b expected=10", ALUOp[0]);
        end
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        exp = expWord(PH_FETCH, 1'b0, 1'b0);
        checks++;
        if (obsWord(0) !== exp || cntA !== 32'd0) begin
            failures++;
            $display("FAIL abort_async got=%b/%0d expected=%b/0", obsWord(0), cntA, exp);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (RegWrite[0] !== 1'b0 || cntA !== 32'd0) begin
            failures++;
            $display("FAIL abort_hold got RegWrite=%b count=%0d expected 0/0", RegWrite[0], cntA);
        end
        @(negedge clk);
        reset = 1'b0;
        expCount = 0;
        runInstr(C_SW, 0, 0, 0, cyc);
    endtask

    task automatic test_random(input int d, input int n);
        int cyc;
        logic [5:0] op;
        doReset();
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(6, 0))
                0: op = C_LW;
                1: op = C_SW;
                2: op = C_RTYPE;
                3: op = C_BEQ;
                4: op = C_ADDI;
                5: op = C_J;
                default: op = 6'($urandom);
            endcase
            runInstr(op, d, -1, -1, cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        opcode = 6'b0;
        mem_ready = 1'b0;
        expCount = 0;
        #12;
        test_reset();
        test_lw_sw();
        test_mem_wait();
        test_branch_jump();
        test_illegal_disabled();
        test_counter_wrap();
        test_reset_abort();
        test_random(0, 60);
        test_random(1, 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
